// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one ROM/RAM memory port between instruction fetch (IF)
// and load/store (LS), blocks ROM writes and keeps IF from being starved.
module mem_arbiter #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_LIMIT    = 32'h1000_0000,
    parameter int unsigned           STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_valid_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  ls_valid_o,
    output logic                  ls_err_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam int unsigned STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  grant_ls_q, grant_ls_d;
    logic                  is_write_q, is_write_d;
    logic                  err_q, err_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  ls_valid_q, ls_valid_d;
    logic                  ls_err_q, ls_err_d;
    logic                  busy_q, busy_d;

    logic any_req;
    logic pick_ls;
    logic ls_rom_write;

    assign any_req      = if_req_i | ls_req_i;
    // LS wins contention unless IF has already lost STARVE_LIMIT times in a row
    assign pick_ls      = ls_req_i & (~if_req_i | (streak_q != STREAK_MAX));
    assign ls_rom_write = ls_we_i & (ls_addr_i < ROM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            grant_ls_q  <= 1'b0;
            is_write_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            ls_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            grant_ls_q  <= grant_ls_d;
            is_write_q  <= is_write_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            ls_err_q    <= ls_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        streak_d    = streak_q;
        grant_ls_d  = grant_ls_q;
        is_write_d  = is_write_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_we_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        ls_err_d    = 1'b0;
        busy_d      = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_ls_d = pick_ls;
                    if (pick_ls) begin
                        mem_addr_d  = ls_addr_i;
                        mem_wdata_d = ls_wdata_i;
                        is_write_d  = ls_we_i;
                        err_d       = ls_rom_write;
                        mem_we_d    = ls_we_i & ~ls_rom_write;
                        if (!if_req_i) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        mem_addr_d = if_addr_i;
                        is_write_d = 1'b0;
                        err_d      = 1'b0;
                        streak_d   = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (!is_write_q) begin
                    if (grant_ls_q) ls_rdata_d = mem_rdata_i;
                    else            if_rdata_d = mem_rdata_i;
                end
                if_valid_d = ~grant_ls_q;
                ls_valid_d = grant_ls_q;
                ls_err_d   = grant_ls_q & err_q;
            end
            S_RESP: begin
            end
            default: begin
            end
        endcase
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_valid_o  = ls_valid_q;
    assign ls_err_o    = ls_err_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// reset/contention sequences, then random traffic against a transaction model.
module tb_mem_arbiter;

    localparam int unsigned DW           = 32;
    localparam logic [31:0] ROM_LIMIT    = 32'h1000_0000;
    localparam int          STARVE_LIMIT = 4;
    localparam int          N_RAND       = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, ls_req, ls_we;
    logic [DW-1:0] if_addr, ls_addr, ls_wdata;
    logic [DW-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic          if_valid, ls_valid, ls_err, mem_we, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH  (DW),
        .ROM_LIMIT   (ROM_LIMIT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_valid_o (if_valid),
        .ls_req_i   (ls_req),
        .ls_we_i    (ls_we),
        .ls_addr_i  (ls_addr),
        .ls_wdata_i (ls_wdata),
        .ls_rdata_o (ls_rdata),
        .ls_valid_o (ls_valid),
        .ls_err_o   (ls_err),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy)
    );

    // Memory system: fixed ROM contents below ROM_LIMIT, small RAM above it
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_F00D;
    endfunction

    logic [31:0] env_ram [256];
    assign mem_rdata = (mem_addr < ROM_LIMIT) ? rom_word(mem_addr) : env_ram[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we && mem_addr >= ROM_LIMIT) env_ram[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_busy"},     busy,     1'b0);
        check_b({tag, "_if_valid"}, if_valid, 1'b0);
        check_b({tag, "_ls_valid"}, ls_valid, 1'b0);
        check_b({tag, "_ls_err"},   ls_err,   1'b0);
        check_b({tag, "_mem_we"},   mem_we,   1'b0);
        check({tag, "_mem_addr"},   mem_addr,  32'h0);
        check({tag, "_mem_wdata"},  mem_wdata, 32'h0);
        check({tag, "_if_rdata"},   if_rdata,  32'h0);
        check({tag, "_ls_rdata"},   ls_rdata,  32'h0);
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        exp_if_v;
        logic        exp_ls_v;
        logic        exp_err;
        logic        exp_mwe;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // Random-phase reference model state
    int          t, free_at, g_cycle, streak;
    bit          g_ls, g_we, g_err;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [31:0] exp_if_rd, exp_ls_rd, exp_maddr;
    logic [31:0] ref_ram [256];
    bit          if_pend, ls_pend;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_ram[i] = '0;
            ref_ram[i] = '0;
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, if_v, ls_v, err, mwe, maddr, rdata
        vecs[0] = '{1, 32'h0000_0004, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0000_0004, rom_word(32'h4)};
        vecs[1] = '{0, 32'h0, 1, 1, 32'h1000_0008, 32'hDEAD_BEEF, 0, 1, 0, 1, 32'h1000_0008, 32'h0};
        vecs[2] = '{0, 32'h0, 1, 0, 32'h1000_0008, 32'h0, 0, 1, 0, 0, 32'h1000_0008, 32'hDEAD_BEEF};
        vecs[3] = '{0, 32'h0, 1, 1, 32'h0000_0010, 32'h0000_1234, 0, 1, 1, 0, 32'h0000_0010, 32'h0};
        vecs[4] = '{1, 32'h0000_0010, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0000_0010, rom_word(32'h10)};
        vecs[5] = '{1, 32'h1000_0008, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h1000_0008, 32'hDEAD_BEEF};
        vecs[6] = '{1, 32'h0000_0008, 1, 0, 32'h1000_0008, 32'h0, 0, 1, 0, 0, 32'h1000_0008, 32'hDEAD_BEEF};

        foreach (vecs[i]) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            ls_req = vecs[i].ls_req; ls_we = vecs[i].ls_we;
            ls_addr = vecs[i].ls_addr; ls_wdata = vecs[i].ls_wdata;
            tick();
            check_b($sformatf("v%0d_acc_busy", i), busy, 1'b1);
            check($sformatf("v%0d_acc_maddr", i), mem_addr, vecs[i].exp_maddr);
            check_b($sformatf("v%0d_acc_mwe", i), mem_we, vecs[i].exp_mwe);
            check_b($sformatf("v%0d_acc_valid", i), if_valid | ls_valid, 1'b0);
            if (vecs[i].exp_mwe) check($sformatf("v%0d_acc_wdata", i), mem_wdata, vecs[i].ls_wdata);
            tick();
            check_b($sformatf("v%0d_if_valid", i), if_valid, vecs[i].exp_if_v);
            check_b($sformatf("v%0d_ls_valid", i), ls_valid, vecs[i].exp_ls_v);
            check_b($sformatf("v%0d_ls_err", i), ls_err, vecs[i].exp_err);
            check_b($sformatf("v%0d_resp_mwe", i), mem_we, 1'b0);
            if (vecs[i].exp_if_v) check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_ls_v && !vecs[i].ls_we)
                check($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].exp_rdata);
            idle_inputs();
            tick();
            check_b($sformatf("v%0d_idle_busy", i), busy, 1'b0);
            check_b($sformatf("v%0d_idle_valid", i), if_valid | ls_valid, 1'b0);
        end

        // Reset during the ACCESS cycle of an LS read
        ls_req = 1'b1; ls_addr = 32'h1000_0008;
        tick();
        check_b("rst_mid_in_access", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        check_all_zero("rst_mid");
        tick();
        check_b("rst_mid_no_pulse", ls_valid, 1'b0);
        if_req = 1'b1; if_addr = 32'h0000_0020;
        tick();
        tick();
        check_b("post_rst_if_valid", if_valid, 1'b1);
        check("post_rst_if_rdata", if_rdata, rom_word(32'h20));
        idle_inputs();
        tick();

        // Continuous contention: four LS grants, then one forced IF grant
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = ROM_LIMIT + 32'h100;
        for (int g = 0; g < 10; g++) begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (if_valid || ls_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                check_b($sformatf("grant%0d_timeout", g), 1'b0, 1'b1);
                break;
            end
            check_b($sformatf("grant%0d_both", g), if_valid & ls_valid, 1'b0);
            check_b($sformatf("grant%0d_is_ls", g), ls_valid, (g % 5) != 4);
        end
        idle_inputs();
        tick();
        tick();

        // Random traffic against the transaction-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        free_at = 0; g_cycle = -10; streak = 0;
        g_ls = 0; g_we = 0; g_err = 0;
        g_addr = '0; g_wdata = '0; g_rdata = '0;
        exp_if_rd = '0; exp_ls_rd = '0; exp_maddr = '0;
        if_pend = 0; ls_pend = 0;
        for (t = 0; t < N_RAND; t++) begin
            bit acc, resp;
            acc  = (t == g_cycle + 1);
            resp = (t == g_cycle + 2);
            if (acc) exp_maddr = g_addr;
            if (resp && !g_we) begin
                if (g_ls) exp_ls_rd = g_rdata;
                else      exp_if_rd = g_rdata;
            end
            check_b("rnd_busy", busy, acc | resp);
            check_b("rnd_if_valid", if_valid, resp & ~g_ls);
            check_b("rnd_ls_valid", ls_valid, resp & g_ls);
            check_b("rnd_ls_err", ls_err, resp & g_ls & g_err);
            check_b("rnd_mem_we", mem_we, acc & g_ls & g_we & ~g_err);
            check("rnd_mem_addr", mem_addr, exp_maddr);
            if (acc && g_ls && g_we && !g_err) check("rnd_mem_wdata", mem_wdata, g_wdata);
            check("rnd_if_rdata", if_rdata, exp_if_rd);
            check("rnd_ls_rdata", ls_rdata, exp_ls_rd);

            if (resp) begin
                if (g_ls) begin ls_pend = 0; ls_req = 1'b0; end
                else      begin if_pend = 0; if_req = 1'b0; end
            end
            if (!if_pend && $urandom_range(2, 0) == 0) begin
                if_pend = 1;
                if_req  = 1'b1;
                if_addr = ($urandom_range(1, 0) == 0) ? {22'h0, 8'($urandom), 2'b00}
                                                       : ROM_LIMIT + {22'h0, 1'b1, 7'($urandom), 2'b00};
            end
            if (!ls_pend && $urandom_range(2, 0) == 0) begin
                ls_pend  = 1;
                ls_req   = 1'b1;
                ls_we    = 1'($urandom);
                ls_wdata = $urandom;
                ls_addr  = ($urandom_range(3, 0) == 0) ? {22'h0, 8'($urandom), 2'b00}
                                                        : ROM_LIMIT + {22'h0, 1'b1, 7'($urandom), 2'b00};
            end

            if (t == free_at) begin
                if (if_req || ls_req) begin
                    g_ls = ls_req && (!if_req || streak != STARVE_LIMIT);
                    if (g_ls) begin
                        g_addr  = ls_addr;
                        g_wdata = ls_wdata;
                        g_we    = ls_we;
                        g_err   = ls_we && (ls_addr < ROM_LIMIT);
                        streak  = if_req ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
                    end else begin
                        g_addr = if_addr;
                        g_we   = 0;
                        g_err  = 0;
                        streak = 0;
                    end
                    if (!g_we)
                        g_rdata = (g_addr < ROM_LIMIT) ? rom_word(g_addr) : ref_ram[g_addr[9:2]];
                    else if (!g_err)
                        ref_ram[g_addr[9:2]] = g_wdata;
                    g_cycle = t;
                    free_at = t + 3;
                end else begin
                    free_at = t + 1;
                end
            end
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory system (ROM below a boundary address, RAM above it, one address/write port, combinational read data) between two requesters: instruction fetch (IF) and load/store (LS).
- Registers the winning request onto the memory port, captures the read data, and returns it with a one-cycle valid pulse.
- Blocks LS writes that target the ROM region.
- Guarantees that IF is not starved by LS traffic.

Parameters:
- DATA_WIDTH, 32, width of addresses and data on all ports.
- ROM_LIMIT, 32'h1000_0000, addresses below this value are ROM (read-only); addresses at or above it are RAM.
- STARVE_LIMIT, 4, maximum consecutive contested LS grants before IF is forced to win.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req_i  input  1  IF access request; held until if_valid_o.
- if_addr_i  input  DATA_WIDTH  IF read address.
- if_rdata_o  output  DATA_WIDTH  IF read data; valid when if_valid_o=1.
- if_valid_o  output  1  one-cycle IF completion pulse.
- ls_req_i  input  1  LS access request; held until ls_valid_o.
- ls_we_i  input  1  1=write, 0=read.
- ls_addr_i  input  DATA_WIDTH  LS address.
- ls_wdata_i  input  DATA_WIDTH  LS write data.
- ls_rdata_o  output  DATA_WIDTH  LS read data; valid when ls_valid_o=1 and the access was a read.
- ls_valid_o  output  1  one-cycle LS completion pulse (reads and writes).
- ls_err_o  output  1  pulses together with ls_valid_o when a write targeted the ROM region.
- mem_we_o  output  1  write enable to the memory system.
- mem_addr_o  output  DATA_WIDTH  address to the memory system.
- mem_wdata_o  output  DATA_WIDTH  write data to the memory system.
- mem_rdata_i  input  DATA_WIDTH  combinational read data from the memory system.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, at the rising edge with reset=1) applies regardless of state:
  - state=IDLE, streak=0.
  - All outputs 0, including mem_addr_o, mem_wdata_o, if_rdata_o and ls_rdata_o.
- FSM states: IDLE, ACCESS, RESP.
  - Requests are sampled only in IDLE.
  - ACCESS and RESP last exactly one cycle each.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner, register its address/wdata onto mem_addr_o/mem_wdata_o, record the winner and the write/err flags, go to ACCESS.
  - mem_addr_o and mem_wdata_o hold their last values while in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: LS wins unless streak==STARVE_LIMIT, in which case IF wins.
- Streak counter (saturates at STARVE_LIMIT):
  - Increments on an LS grant while if_req_i=1.
  - Clears on an IF grant.
  - Clears on an LS grant while if_req_i=0.
- ACCESS:
  - mem_we_o=1 only for a non-error LS write; the RAM commits at the edge ending ACCESS.
  - Error condition: ls_we_i=1 and ls_addr_i < ROM_LIMIT (unsigned compare). The write is suppressed, mem_we_o stays 0 and memory is untouched.
  - Reads: mem_rdata_i is captured at the edge ending ACCESS into if_rdata_o or ls_rdata_o (winner only). The other rdata register holds its value.
  - Writes: ls_rdata_o holds its value.
  - Go to RESP.
- RESP:
  - The winner's valid is 1 for this cycle only.
  - ls_err_o=1 in this cycle if the error flag is set.
  - mem_we_o=0. Return to IDLE.
- Timing and protocol:
  - Latency: request seen in IDLE at cycle k → ACCESS at k+1 → valid at k+2.
  - Throughput: one access per 3 cycles.
  - A requester must hold req/addr/we/wdata stable from assertion through its valid cycle. It may deassert or change them in the valid cycle.
  - A req that is still high in the IDLE cycle after RESP is treated as a new request.
- Reset mid-operation:
  - Reset asserted during ACCESS of a write: the RAM still commits at that edge, because it samples the same edge. No valid pulse follows.
  - Reset during RESP: the pulse is cut after the current cycle.
- Simultaneous events: the other requester's req raised during ACCESS/RESP is ignored until IDLE and is not lost if held.
- if_addr_i in the RAM region is a legal read. IF never writes.

Test Plan:
- IF only: if_req_i=1, if_addr_i=0x0000_0004 at cycle 0 → mem_addr_o=0x0000_0004 at cycle 1; if_valid_o=1 at cycle 2 with if_rdata_o = ROM word 1; mem_we_o=0 throughout.
- LS write then read: write 0xDEADBEEF to 0x1000_0008 → mem_we_o=1 for exactly the ACCESS cycle, ls_valid_o=1, ls_err_o=0. A following read of 0x1000_0008 → ls_rdata_o=0xDEADBEEF.
- ROM write blocked: ls_we_i=1, ls_addr_i=0x0000_0010, ls_wdata_i=0x1234 → mem_we_o stays 0, ls_valid_o=1 with ls_err_o=1. A subsequent IF read of 0x10 returns the original ROM word.
- Contention/starvation: hold if_req_i and ls_req_i high continuously with STARVE_LIMIT=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; never 5 consecutive LS grants.
- Back-to-back: LS keeps req high with a new address in its valid cycle → its new access starts from the next IDLE; if_valid_o and ls_valid_o are never high together.
- Reset mid-access: assert reset in ACCESS of an LS read → next cycle busy_o=0, ls_valid_o=0, all outputs 0; a fresh request afterwards completes normally in 3 cycles.
